sd_block_write_engine: RTL and testbench

- Parametrised SPI-mode SD data-block transmitter; successor to the CMD24 single-word writer.
- Streams a full block from a word handshake, with optional lead-in gap, 0xFE start token, CRC16 and data-response parsing.
- Waits out card busy and reports a status code.
- Sits between the SD command sequencer, which issues CMD24 and pulses START, and the SPI pins (DI out, DO in).

---
 rtl/sd_block_write_engine.sv | 256 +++++++++++++++++++++++++
 tb/tb_sd_block_write_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_write_engine.sv
// SPI-mode SD data-block transmitter: lead-in gap, 0xFE token, streamed payload,
// CRC16, data-response decode and card-busy wait, reporting a 3-bit status.
module sd_block_write_engine #(
  parameter int DATA_WIDTH   = 16,
  parameter int BLOCK_BYTES  = 512,
  parameter int GAP_BYTES    = 1,
  parameter bit CRC_ENABLE   = 1'b1,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] WORD_DATA,
  input  logic                  WORD_VALID,
  output logic                  WORD_READY,
  input  logic                  DO,
  output logic                  DI,
  output logic                  BUSY,
  output logic                  WRITE_FINISH,
  output logic [2:0]            STATUS,
  output logic                  UNDERRUN,
  output logic [2:0]            state_dbg
);

  localparam int DATA_BITS = 8 * BLOCK_BYTES;
  localparam int CNT_W     = $clog2(DATA_BITS + 16 + 1);
  localparam int WB_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(8 * GAP_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_3     = CNT_W'(3);
  localparam logic [CNT_W-1:0] CNT_6     = CNT_W'(6);
  localparam logic [CNT_W-1:0] CNT_7     = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_15    = CNT_W'(15);
  localparam logic [WB_W-1:0]  WB_LAST   = WB_W'(DATA_WIDTH - 1);
  localparam logic [31:0]      BUSY_LAST = 32'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_TOKEN, S_DATA, S_CRC, S_RESP, S_WAIT_BUSY, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WB_W-1:0]       wbit_q, wbit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [15:0]           crc_q, crc_d;
  logic                  di_q, di_d;
  logic                  busy_q, busy_d;
  logic                  finish_q, finish_d;
  logic                  ready_q, ready_d;
  logic [2:0]            status_q, status_d;
  logic                  underrun_q, underrun_d;
  logic                  got_start_q, got_start_d;
  logic [2:0]            resp_q, resp_d;
  logic [31:0]           busy_cnt_q, busy_cnt_d;
  logic                  do_q;

  logic                  load_word, shift_word;
  logic [DATA_WIDTH-1:0] word;
  logic [15:0]           crc_out;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // Card output is launched on the falling edge, so sample it mid-bit.
  always_ff @(posedge CLK) do_q <= DO;

  // Word handshake: at a falling-edge word boundary with WORD_VALID high the
  // word is latched, and WORD_READY is high for the following cycle to say so.
  // The producer then has DATA_WIDTH cycles to present the next word; a word
  // not valid at its boundary is replaced by ones and never retried.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wbit_d      = wbit_q;
    shreg_d     = shreg_q;
    crc_d       = crc_q;
    di_d        = 1'b1;
    busy_d      = busy_q;
    finish_d    = 1'b0;
    ready_d     = 1'b0;
    status_d    = status_q;
    underrun_d  = underrun_q;
    got_start_d = got_start_q;
    resp_d      = resp_q;
    busy_cnt_d  = busy_cnt_q;
    load_word   = 1'b0;
    shift_word  = 1'b0;
    word        = '1;
    crc_out     = CRC_ENABLE ? crc_q : 16'hFFFF;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          busy_d     = 1'b1;
          status_d   = 3'd0;
          underrun_d = 1'b0;
          crc_d      = 16'h0000;
          cnt_d      = '0;
          state_d    = (GAP_BYTES == 0) ? S_TOKEN : S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_TOKEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TOKEN: begin
        if (cnt_q == CNT_7) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          load_word = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          di_d  = (cnt_q != CNT_6);  // 0xFE: only the final token bit is 0
        end
      end
      S_DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = S_CRC;
          cnt_d   = '0;
          di_d    = crc_out[15];
          crc_d   = {crc_out[14:0], 1'b1};
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (wbit_q == WB_LAST) load_word = 1'b1;
          else shift_word = 1'b1;
        end
      end
      S_CRC: begin
        if (cnt_q == CNT_15) begin
          state_d     = S_RESP;
          cnt_d       = '0;
          got_start_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          di_d  = crc_q[15];
          crc_d = {crc_q[14:0], 1'b1};
        end
      end
      S_RESP: begin
        if (!got_start_q) begin
          if (!do_q) begin
            got_start_d = 1'b1;
            cnt_d       = '0;
          end else if (cnt_q == CNT_7) begin
            status_d = 3'd3;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          resp_d = {resp_q[1:0], do_q};
          if (cnt_q == CNT_3) begin
            // resp_q now holds r[3:1]; r[0] is not part of the code.
            case (resp_q)
              3'b010: begin
                status_d   = 3'd0;
                busy_cnt_d = '0;
                state_d    = S_WAIT_BUSY;
              end
              3'b101: begin status_d = 3'd1; state_d = S_DONE; end
              3'b110: begin status_d = 3'd2; state_d = S_DONE; end
              default: begin status_d = 3'd7; state_d = S_DONE; end
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WAIT_BUSY: begin
        if (do_q) begin
          state_d = S_DONE;
        end else if (busy_cnt_q == BUSY_LAST) begin
          status_d = 3'd4;
          state_d  = S_DONE;
        end else begin
          busy_cnt_d = busy_cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_word) begin
      if (WORD_VALID) begin
        word    = WORD_DATA;
        ready_d = 1'b1;
      end else begin
        underrun_d = 1'b1;
      end
      wbit_d = '0;
    end else if (shift_word) begin
      word   = shreg_q;
      wbit_d = wbit_q + 1'b1;
    end

    if (load_word || shift_word) begin
      di_d    = word[DATA_WIDTH-1];
      shreg_d = (word << 1) | DATA_WIDTH'(1);
      crc_d   = crc_step(crc_q, word[DATA_WIDTH-1]);
    end

    finish_d = (state_d == S_DONE);
  end

  always_ff @(negedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wbit_q      <= '0;
      shreg_q     <= '1;
      crc_q       <= 16'h0000;
      di_q        <= 1'b1;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      ready_q     <= 1'b0;
      status_q    <= 3'd0;
      underrun_q  <= 1'b0;
      got_start_q <= 1'b0;
      resp_q      <= '0;
      busy_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wbit_q      <= wbit_d;
      shreg_q     <= shreg_d;
      crc_q       <= crc_d;
      di_q        <= di_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      ready_q     <= ready_d;
      status_q    <= status_d;
      underrun_q  <= underrun_d;
      got_start_q <= got_start_d;
      resp_q      <= resp_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign DI           = di_q;
  assign BUSY         = busy_q;
  assign WRITE_FINISH = finish_q;
  assign WORD_READY   = ready_q;
  assign STATUS       = status_q;
  assign UNDERRUN     = underrun_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_sd_block_write_engine.sv
// Directed bench: three engine configurations share stimulus lines and a small
// card model; DI streams are compared against a bench-built expected stream.
module tb_sd_block_write_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [15:0] word_data = 16'hFFFF;
  logic        word_valid = 1'b0;
  logic        do_line = 1'b1;

  logic       ready_a, ready_b, ready_c;
  logic       di_a, di_b, di_c;
  logic       busy_a, busy_b, busy_c;
  logic       fin_a, fin_b, fin_c;
  logic [2:0] status_a, status_b, status_c;
  logic       under_a, under_b, under_c;
  logic [2:0] state_a, state_b, state_c;

  int         sel = 0;
  logic       m_di, m_busy, m_finish, m_ready, m_underrun;
  logic [2:0] m_status;

  int errors = 0;
  int checks = 0;

  logic [15:0] words_mem [0:255];
  logic        valid_mem [0:255];
  logic [0:0]  exp_q [$];
  logic        di_bits [$];
  int          ready_cnt, finish_cnt, lat;
  logic [2:0]  fin_status;
  logic        fin_underrun, busy_after;
  logic [15:0] model_crc;

  always #5 clk = ~clk;

  sd_block_write_engine #(.DATA_WIDTH(16), .BLOCK_BYTES(512), .GAP_BYTES(1),
                          .CRC_ENABLE(1'b1), .BUSY_TIMEOUT(65535)) dut_a (
    .CLK(clk), .RST_N(rst_n), .START(start_a), .WORD_DATA(word_data),
    .WORD_VALID(word_valid), .WORD_READY(ready_a), .DO(do_line), .DI(di_a),
    .BUSY(busy_a), .WRITE_FINISH(fin_a), .STATUS(status_a), .UNDERRUN(under_a),
    .state_dbg(state_a));

  sd_block_write_engine #(.DATA_WIDTH(8), .BLOCK_BYTES(4), .GAP_BYTES(1),
                          .CRC_ENABLE(1'b0), .BUSY_TIMEOUT(100)) dut_b (
    .CLK(clk), .RST_N(rst_n), .START(start_b), .WORD_DATA(word_data[7:0]),
    .WORD_VALID(word_valid), .WORD_READY(ready_b), .DO(do_line), .DI(di_b),
    .BUSY(busy_b), .WRITE_FINISH(fin_b), .STATUS(status_b), .UNDERRUN(under_b),
    .state_dbg(state_b));

  sd_block_write_engine #(.DATA_WIDTH(16), .BLOCK_BYTES(8), .GAP_BYTES(1),
                          .CRC_ENABLE(1'b1), .BUSY_TIMEOUT(65535)) dut_c (
    .CLK(clk), .RST_N(rst_n), .START(start_c), .WORD_DATA(word_data),
    .WORD_VALID(word_valid), .WORD_READY(ready_c), .DO(do_line), .DI(di_c),
    .BUSY(busy_c), .WRITE_FINISH(fin_c), .STATUS(status_c), .UNDERRUN(under_c),
    .state_dbg(state_c));

  always_comb begin
    case (sel)
      1: begin
        m_di = di_b; m_busy = busy_b; m_finish = fin_b; m_ready = ready_b;
        m_status = status_b; m_underrun = under_b;
      end
      2: begin
        m_di = di_c; m_busy = busy_c; m_finish = fin_c; m_ready = ready_c;
        m_status = status_c; m_underrun = under_c;
      end
      default: begin
        m_di = di_a; m_busy = busy_a; m_finish = fin_a; m_ready = ready_a;
        m_status = status_a; m_underrun = under_a;
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic card_bit(input int j, input logic [4:0] resp, input int busy_cyc);
    if (j < 5) return resp[4-j];
    if (j < 5 + busy_cyc) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] get_field(input int first, input int len);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < len; i++)
      v = {v[30:0], (first + i < di_bits.size()) ? di_bits[first + i] : 1'bx};
    return v;
  endfunction

  task automatic set_start(input int s, input logic v);
    case (s)
      1: start_b = v;
      2: start_c = v;
      default: start_a = v;
    endcase
  endtask

  task automatic build_expected(input int dw, input int bb, input bit crc_en);
    logic [15:0] crc;
    logic b;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    for (int i = 7; i >= 0; i--) exp_q.push_back(i != 0);
    crc = 16'h0000;
    for (int w = 0; w < (8 * bb) / dw; w++) begin
      for (int i = dw - 1; i >= 0; i--) begin
        b = valid_mem[w] ? words_mem[w][i] : 1'b1;
        exp_q.push_back(b);
        crc = crc_bit(crc, b);
      end
    end
    if (!crc_en) crc = 16'hFFFF;
    model_crc = crc;
    for (int i = 15; i >= 0; i--) exp_q.push_back(crc[i]);
  endtask

  task automatic check_stream(input string tag);
    int mism, zeros;
    mism = 0;
    zeros = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= di_bits.size() || di_bits[i] !== exp_q[i][0]) mism++;
    for (int i = exp_q.size(); i < di_bits.size(); i++)
      if (di_bits[i] !== 1'b1) zeros++;
    check({tag, "_bit_errors"}, 32'(mism), 32'd0);
    check({tag, "_resp_di_high"}, 32'(zeros), 32'd0);
  endtask

  // One block: START, feed words by bit position, model the card, collect DI.
  task automatic run_block(input int s, input int dw, input int bb, input logic [4:0] resp,
                           input int busy_cyc, input int abort_at);
    int total, c, j, k, cyc, t_crc, post;
    total = 16 + 8 * bb + 16;
    di_bits.delete();
    ready_cnt = 0; finish_cnt = 0; lat = -1;
    j = -1; cyc = 0; t_crc = -1; post = -1;
    fin_status = 3'bx; fin_underrun = 1'bx; busy_after = 1'bx;
    @(posedge clk);
    sel = s;
    word_data = words_mem[0];
    word_valid = valid_mem[0];
    set_start(s, 1'b1);
    while (post != 0 && cyc < total + 1500) begin
      @(negedge clk);
      if (j >= 0) begin
        do_line = card_bit(j, resp, busy_cyc);
        j++;
      end
      @(posedge clk);
      cyc++;
      set_start(s, 1'b0);
      if (post > 0) begin
        if (post == 3) busy_after = m_busy;
        post--;
      end
      if (m_busy) di_bits.push_back(m_di);
      if (m_ready) ready_cnt++;
      if (m_finish) begin
        finish_cnt++;
        fin_status = m_status;
        fin_underrun = m_underrun;
        lat = cyc - t_crc;
        if (post < 0) post = 3;
      end
      c = di_bits.size();
      if (c == total && t_crc < 0) begin
        t_crc = cyc;
        j = 0;
      end
      k = (c <= 16) ? 0 : (c - 16 + dw - 1) / dw;
      if (k > 255) k = 255;
      word_data = words_mem[k];
      word_valid = valid_mem[k];
      if (abort_at > 0 && c == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        check("abort_di", 32'(m_di), 32'd1);
        check("abort_busy", 32'(m_busy), 32'd0);
        check("abort_finish", 32'(m_finish), 32'd0);
        rst_n = 1'b1;
        repeat (30) begin
          @(posedge clk);
          if (m_finish) finish_cnt++;
        end
        post = 0;
      end
    end
    check("run_ended", 32'(post != 0), 32'd0);
    do_line = 1'b1;
    word_valid = 1'b0;
  endtask

  task automatic fill_words(input logic [15:0] v);
    for (int i = 0; i < 256; i++) begin
      words_mem[i] = v;
      valid_mem[i] = 1'b1;
    end
  endtask

  initial begin
    fill_words(16'hFFFF);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_di", 32'(di_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_finish", 32'(fin_a), 32'd0);
    check("rst_ready", 32'(ready_a), 32'd0);
    check("rst_status", 32'(status_a), 32'd0);
    check("rst_underrun", 32'(under_a), 32'd0);
    check("rst_state", 32'(state_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full 512-byte block of ones, accepted, 3 busy cycles.
    build_expected(16, 512, 1'b1);
    run_block(0, 16, 512, 5'b00101, 3, 0);
    check_stream("t1");
    check("t1_crc", get_field(16 + 4096, 16), 32'h7FA1);
    check("t1_ready", 32'(ready_cnt), 32'd256);
    check("t1_finish", 32'(finish_cnt), 32'd1);
    check("t1_status", 32'(fin_status), 32'd0);
    check("t1_underrun", 32'(fin_underrun), 32'd0);
    check("t1_busy_drop", 32'(busy_after), 32'd0);

    // 4-byte block of bytes, CRC disabled.
    fill_words(16'h0000);
    words_mem[0] = 16'h0001; words_mem[1] = 16'h0002;
    words_mem[2] = 16'h0003; words_mem[3] = 16'h0004;
    build_expected(8, 4, 1'b0);
    run_block(1, 8, 4, 5'b00101, 3, 0);
    check_stream("t2");
    check("t2_data", get_field(16, 32), 32'h01020304);
    check("t2_crc", get_field(48, 16), 32'h0000FFFF);
    check("t2_ready", 32'(ready_cnt), 32'd4);
    check("t2_status", 32'(fin_status), 32'd0);
    check("t2_finish", 32'(finish_cnt), 32'd1);

    // Missing second word of four is padded with ones.
    fill_words(16'h0000);
    words_mem[0] = 16'h1234; words_mem[1] = 16'hABCD;
    words_mem[2] = 16'h5678; words_mem[3] = 16'h9ABC;
    valid_mem[1] = 1'b0;
    build_expected(16, 8, 1'b1);
    run_block(2, 16, 8, 5'b00101, 3, 0);
    check_stream("t5");
    check("t5_pad_word", get_field(32, 16), 32'h0000FFFF);
    check("t5_crc", get_field(16 + 64, 16), 32'(model_crc));
    check("t5_ready", 32'(ready_cnt), 32'd3);
    check("t5_underrun", 32'(fin_underrun), 32'd1);
    check("t5_status", 32'(fin_status), 32'd0);
    valid_mem[1] = 1'b1;

    // CRC-error response: busy wait skipped, finish 6 cycles after last CRC bit.
    run_block(2, 16, 8, 5'b01011, 20, 0);
    check("t3_status", 32'(fin_status), 32'd1);
    check("t3_latency", 32'(lat), 32'd6);
    check("t3_finish", 32'(finish_cnt), 32'd1);
    check("t3_underrun_cleared", 32'(fin_underrun), 32'd0);

    // No start bit at all.
    run_block(2, 16, 8, 5'b11111, 0, 0);
    check("t4_noresp_status", 32'(fin_status), 32'd3);
    check("t4_noresp_latency", 32'(lat), 32'd9);

    // Accepted, then busy held past a 100-cycle timeout.
    words_mem[0] = 16'h0001; words_mem[1] = 16'h0002;
    words_mem[2] = 16'h0003; words_mem[3] = 16'h0004;
    run_block(1, 8, 4, 5'b00101, 1000, 0);
    check("t4_timeout_status", 32'(fin_status), 32'd4);
    check("t4_timeout_latency", 32'(lat), 32'd106);

    // Reset mid-data, then a clean block.
    fill_words(16'hFFFF);
    run_block(0, 16, 512, 5'b00101, 3, 2000);
    check("t6_abort_no_finish", 32'(finish_cnt), 32'd0);
    fill_words(16'h0000);
    for (int i = 0; i < 256; i++) words_mem[i] = 16'(i * 16'h0101 + 16'h1357);
    build_expected(16, 512, 1'b1);
    run_block(0, 16, 512, 5'b00101, 5, 0);
    check_stream("t6");
    check("t6_status", 32'(fin_status), 32'd0);
    check("t6_finish", 32'(finish_cnt), 32'd1);
    check("t6_ready", 32'(ready_cnt), 32'd256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
